sif_xa2wa_bridge: RTL and testbench

RTL stage between the SIF XA host port and the WA sink port.
- Accepts 16-bit XA writes into a small FIFO and forwards them on WA with a valid/ready handshake.
- Keeps a wrapping 16-bit checksum of every word delivered on WA; the checksum is returned on XA reads.
- The environment XA/WA monitors and the reference model check this block's behaviour directly.

---
 rtl/sif_xa2wa_bridge.sv | 116 +++++++++++
 tb/tb_sif_xa2wa_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sif_xa2wa_bridge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sif_xa2wa_bridge : XA write FIFO to WA valid/ready sink, checksum on read |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module sif_xa2wa_bridge #(
  parameter int DEPTH     = 4,
  parameter int DW        = 16,
  parameter bit CLR_ON_RD = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xa_wr_s,
  input  logic          xa_rd_s,
  input  logic [DW-1:0] xa_data_in,
  output logic [DW-1:0] xa_data_out,
  output logic          xa_rd_valid,
  output logic          xa_full,
  output logic          wa_valid,
  output logic [DW-1:0] wa_data,
  input  logic          wa_ready,
  output logic          err_ovf,
  output logic          err_ill
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q;
  logic          ovf_q, ovf_d;
  logic          ill_q, ill_d;

  logic w_wr, w_rd, w_ill, w_push, w_pop;

  assign w_wr   = xa_wr_s & ~xa_rd_s;
  assign w_rd   = xa_rd_s & ~xa_wr_s;
  assign w_ill  = xa_wr_s & xa_rd_s;
  // Acceptance uses the registered full flag, so a same-cycle pop never frees room for a write.
  assign w_push = w_wr & ~full_q;
  assign w_pop  = wa_valid & wa_ready;

  assign wa_valid    = (count_q != '0);
  assign wa_data     = wa_valid ? mem_q[rd_ptr_q] : '0;
  assign xa_full     = full_q;
  assign xa_data_out = rd_data_q;
  assign xa_rd_valid = rd_valid_q;
  assign err_ovf     = ovf_q;
  assign err_ill     = ill_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    csum_d    = csum_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q | (w_wr & full_q);
    ill_d     = ill_q | w_ill;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL_CNT);

    if (w_rd) rd_data_d = csum_q;

    // A clearing read still keeps the word popped in the same cycle.
    if (w_pop) begin
      if (CLR_ON_RD && w_rd) csum_d = wa_data;
      else                   csum_d = csum_q + wa_data;
    end else if (CLR_ON_RD && w_rd) begin
      csum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      csum_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      csum_q     <= csum_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= w_rd;
      ovf_q      <= ovf_d;
      ill_q      <= ill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= xa_data_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_sif_xa2wa_bridge.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_sif_xa2wa_bridge : directed bench, one accumulating and one clearing DUT|
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_sif_xa2wa_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        xa_wr_s, xa_rd_s, wa_ready;
  logic [15:0] xa_data_in;

  logic [15:0] dout_a, dout_b, wdata_a, wdata_b;
  logic        rv_a, rv_b, full_a, full_b, wv_a, wv_b;
  logic        ovf_a, ovf_b, ill_a, ill_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] cs_a, cs_b;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  sif_xa2wa_bridge #(.DEPTH(4), .DW(16), .CLR_ON_RD(1'b0)) u_acc (
    .clk(clk), .rst(rst), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_in(xa_data_in), .xa_data_out(dout_a), .xa_rd_valid(rv_a),
    .xa_full(full_a), .wa_valid(wv_a), .wa_data(wdata_a), .wa_ready(wa_ready),
    .err_ovf(ovf_a), .err_ill(ill_a)
  );

  sif_xa2wa_bridge #(.DEPTH(4), .DW(16), .CLR_ON_RD(1'b1)) u_clr (
    .clk(clk), .rst(rst), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_data_in(xa_data_in), .xa_data_out(dout_b), .xa_rd_valid(rv_b),
    .xa_full(full_b), .wa_valid(wv_b), .wa_data(wdata_b), .wa_ready(wa_ready),
    .err_ovf(ovf_b), .err_ill(ill_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] d);
    xa_wr_s = 1'b1; xa_data_in = d;
    step();
    xa_wr_s = 1'b0; xa_data_in = 16'h0000;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] exp_a, input logic [15:0] exp_b);
    xa_rd_s = 1'b1;
    step();
    xa_rd_s = 1'b0;
    chk1({tag, "_rv_a"}, rv_a, 1'b1);
    chk1({tag, "_rv_b"}, rv_b, 1'b1);
    chk16({tag, "_data_a"}, dout_a, exp_a);
    chk16({tag, "_data_b"}, dout_b, exp_b);
  endtask

  task automatic drain_one(input string tag, input logic [15:0] exp);
    wa_ready = 1'b1;
    chk1({tag, "_valid"}, wv_a, 1'b1);
    chk16({tag, "_data_a"}, wdata_a, exp);
    chk16({tag, "_data_b"}, wdata_b, exp);
    step();
    wa_ready = 1'b0;
    cs_a = cs_a + exp;
    cs_b = cs_b + exp;
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_wv_a"}, wv_a, 1'b0);
    chk1({tag, "_wv_b"}, wv_b, 1'b0);
    chk1({tag, "_full_a"}, full_a, 1'b0);
    chk1({tag, "_full_b"}, full_b, 1'b0);
    chk1({tag, "_ovf_a"}, ovf_a, 1'b0);
    chk1({tag, "_ovf_b"}, ovf_b, 1'b0);
    chk1({tag, "_ill_a"}, ill_a, 1'b0);
    chk1({tag, "_ill_b"}, ill_b, 1'b0);
    chk1({tag, "_rv_a"}, rv_a, 1'b0);
  endtask

  initial begin
    rst = 1'b1; xa_wr_s = 1'b0; xa_rd_s = 1'b0; wa_ready = 1'b0; xa_data_in = 16'h0000;
    cs_a = 16'h0000; cs_b = 16'h0000;

    // Reset then single write
    step(); step();
    rst = 1'b0;
    chk_reset_state("rst0");
    chk16("rst0_dout", dout_a, 16'h0000);
    chk16("rst0_wdata", wdata_a, 16'h0000);

    wr(16'h1234);
    chk1("single_wv", wv_a, 1'b1);
    chk16("single_wdata", wdata_a, 16'h1234);
    drain_one("single_pop", 16'h1234);
    chk1("single_empty", wv_a, 1'b0);
    rd_chk("rd_single", 16'h1234, 16'h1234);
    cs_b = 16'h0000;
    step();
    chk1("rd_pulse_end", rv_a, 1'b0);
    chk16("rd_hold", dout_a, 16'h1234);

    // Fill and overflow
    wr(16'd1); wr(16'd2); wr(16'd3);
    chk1("fill3_full", full_a, 1'b0);
    wr(16'd4);
    chk1("fill4_full", full_a, 1'b1);
    chk1("fill4_ovf", ovf_a, 1'b0);
    wr(16'd5);
    chk1("ovf_flag_a", ovf_a, 1'b1);
    chk1("ovf_flag_b", ovf_b, 1'b1);
    chk1("ovf_still_full", full_a, 1'b1);
    for (int i = 1; i <= 4; i++) drain_one("fill_seq", 16'(i));
    chk1("fill_drained", wv_a, 1'b0);
    chk1("fill_notfull", full_a, 1'b0);
    rd_chk("rd_fill", 16'h123E, 16'h000A);
    cs_b = 16'h0000;

    // Checksum wrap
    wr(16'hFFFF); wr(16'h0003);
    drain_one("wrap_pop", 16'hFFFF);
    drain_one("wrap_pop", 16'h0003);
    rd_chk("rd_wrap", 16'h1240, 16'h0002);
    cs_b = 16'h0000;

    // Push while full with a same-cycle pop, then streaming at count 2
    rst = 1'b1; step(); rst = 1'b0;
    cs_a = 16'h0000; cs_b = 16'h0000;
    wr(16'h0011); wr(16'h0022); wr(16'h0033); wr(16'h0044);
    chk1("pf_full", full_a, 1'b1);
    wa_ready = 1'b1; xa_wr_s = 1'b1; xa_data_in = 16'h0055;
    step();
    wa_ready = 1'b0; xa_wr_s = 1'b0;
    cs_a = cs_a + 16'h0011; cs_b = cs_b + 16'h0011;
    chk1("pf_ovf", ovf_a, 1'b1);
    chk1("pf_count3_notfull", full_a, 1'b0);
    chk16("pf_head", wdata_a, 16'h0022);
    drain_one("pf_pop", 16'h0022);
    q = {16'h0033, 16'h0044};
    for (int i = 0; i < 12; i++) begin
      chk16("stream_head", wdata_a, q[0]);
      chk1("stream_valid", wv_a, 1'b1);
      wa_ready = 1'b1; xa_wr_s = 1'b1; xa_data_in = 16'h0100 + 16'(i);
      step();
      cs_a = cs_a + q[0]; cs_b = cs_b + q[0];
      void'(q.pop_front());
      q.push_back(16'h0100 + 16'(i));
    end
    wa_ready = 1'b0; xa_wr_s = 1'b0; xa_data_in = 16'h0000;
    chk1("stream_notfull", full_a, 1'b0);
    drain_one("stream_tail", 16'h010A);
    drain_one("stream_tail", 16'h010B);
    chk1("stream_empty", wv_a, 1'b0);
    rd_chk("rd_stream", cs_a, cs_b);
    cs_b = 16'h0000;

    // Illegal op and clear-on-read behaviour
    xa_wr_s = 1'b1; xa_rd_s = 1'b1; xa_data_in = 16'h5555;
    step();
    xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_data_in = 16'h0000;
    chk1("ill_flag", ill_a, 1'b1);
    chk1("ill_no_rv", rv_a, 1'b0);
    chk1("ill_no_push", wv_a, 1'b0);
    step();
    chk1("ill_no_push2", wv_b, 1'b0);

    wr(16'h0010);
    drain_one("clr_pop", 16'h0010);
    rd_chk("rd_clr1", cs_a, 16'h0010);
    cs_b = 16'h0000;
    rd_chk("rd_clr2", cs_a, 16'h0000);

    // Read coinciding with a pop: the popped word survives the clear
    wr(16'h0020);
    wa_ready = 1'b1;
    rd_chk("rd_clr_pop", cs_a, 16'h0000);
    wa_ready = 1'b0;
    cs_a = cs_a + 16'h0020;
    cs_b = 16'h0020;
    rd_chk("rd_after_clr_pop", cs_a, cs_b);

    // Reset in the middle of traffic
    wr(16'h0007); wr(16'h0008); wr(16'h0009);
    wa_ready = 1'b1; step(); wa_ready = 1'b0; step();
    wa_ready = 1'b1; rst = 1'b1; step();
    rst = 1'b0; wa_ready = 1'b0;
    chk_reset_state("rst_mid");
    rd_chk("rd_after_rst", 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
